// File: rtl/key_event_ctrl_pkg.sv
// Shared constants, FSM encoding and event record for the key event controller.
package key_event_ctrl_pkg;

  localparam int KEYS         = 4;
  localparam int KEY_W        = 2;
  localparam int TS_W         = 8;
  localparam int DEBOUNCE_DEF = 4;
  localparam int DEPTH_DEF    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [TS_W-1:0]  ts;
  } evt_t;

  // Fixed-priority pick: the lowest set bit wins.
  function automatic logic [KEY_W-1:0] lowest_index(input logic [KEYS-1:0] vec);
    logic [KEY_W-1:0] idx;
    idx = '0;
    for (int i = KEYS - 1; i >= 0; i--) begin
      if (vec[i]) idx = KEY_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_event_ctrl_debounce.sv
// key_debounce: two-flop synchroniser plus hold-time debouncer for one key.
module key_debounce
  import key_event_ctrl_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  // rise is asserted in the first cycle that level reads 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      rise    <= 1'b0;
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt   <= '0;
        level <= sync_p1;
        rise  <= sync_p1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_event_ctrl.sv
// Key event controller: debounced keys, timestamped press capture and an event FIFO.
module key_event_ctrl
  import key_event_ctrl_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF,
  parameter int DEPTH    = DEPTH_DEF
) (
  input  logic             C,
  input  logic             INIT_N,
  input  logic [KEYS-1:0]  I,
  input  logic             EN,
  input  logic             EVT_READY,
  output logic [KEYS-1:0]  O,
  output logic             EVT_VALID,
  output logic [KEY_W-1:0] EVT_KEY,
  output logic [TS_W-1:0]  EVT_TS,
  output logic             OVERRUN,
  output logic             BUSY
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [1:0]       rst_sync;
  logic             rst_n;
  logic [KEYS-1:0]  rise;
  state_t           state;
  state_t           state_nxt;
  logic [TS_W-1:0]  ts;
  logic [KEYS-1:0]  pending;
  logic [KEYS-1:0]  pending_nxt;
  logic [KEYS-1:0]  capture;
  logic             ovr_hit;
  logic [TS_W-1:0]  stamp [KEYS];
  logic [KEY_W-1:0] sel;
  evt_t             mem [DEPTH];
  evt_t             head;
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;

  // Reset asserts asynchronously, releases on a clock edge
  always_ff @(posedge C or negedge INIT_N) begin
    if (!INIT_N) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  for (genvar k = 0; k < KEYS; k++) begin : g_key
    key_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
      .clk   (C),
      .rst_n (rst_n),
      .raw   (I[k]),
      .level (O[k]),
      .rise  (rise[k])
    );
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (EN) state_nxt = ST_RUN;
      ST_RUN:   if (!EN) state_nxt = ST_FLUSH;
      ST_FLUSH: begin
        if (EN)                          state_nxt = ST_RUN;
        else if (empty && pending == '0) state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge C or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  assign BUSY = (state != ST_IDLE);

  always_ff @(posedge C or negedge rst_n) begin
    if (!rst_n)                                        ts <= '0;
    else if (state == ST_IDLE && state_nxt == ST_RUN) ts <= '0;
    else if (state == ST_RUN)                         ts <= ts + 1'b1;
  end

  // FIFO bookkeeping; a pop frees the slot the same-cycle push needs
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop   = !empty && EVT_READY;
  assign sel   = lowest_index(pending);
  assign push  = (state != ST_IDLE) && (pending != '0) && (!full || pop);

  always_comb begin
    pending_nxt = pending;
    capture     = '0;
    ovr_hit     = 1'b0;
    if (push) pending_nxt[sel] = 1'b0;
    if (state == ST_RUN) begin
      for (int k = 0; k < KEYS; k++) begin
        if (rise[k]) begin
          if (pending[k]) begin
            ovr_hit = 1'b1;
          end else begin
            pending_nxt[k] = 1'b1;
            capture[k]     = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge C or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      OVERRUN <= 1'b0;
      for (int k = 0; k < KEYS; k++) stamp[k] <= '0;
    end else begin
      pending <= pending_nxt;
      if (ovr_hit) OVERRUN <= 1'b1;
      for (int k = 0; k < KEYS; k++) begin
        if (capture[k]) stamp[k] <= ts;
      end
    end
  end

  always_ff @(posedge C or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries data only; occupancy alone decides what is visible
  always_ff @(posedge C) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= {sel, stamp[sel]};
  end

  assign head      = mem[rd_ptr[PTR_W-1:0]];
  assign EVT_VALID = !empty;
  assign EVT_KEY   = empty ? '0 : head.key;
  assign EVT_TS    = empty ? '0 : head.ts;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Self-checking bench for key_event_ctrl: debounce vector table plus scoreboarded event sequences.
module tb_key_event_ctrl;
  import key_event_ctrl_pkg::*;

  localparam int DEB = 4;

  logic       C = 1'b0;
  logic       INIT_N;
  logic [3:0] I;
  logic       EN;
  logic       EVT_READY;
  logic [3:0] O;
  logic       EVT_VALID;
  logic [1:0] EVT_KEY;
  logic [7:0] EVT_TS;
  logic       OVERRUN;
  logic       BUSY;

  key_event_ctrl #(.DEBOUNCE(DEB), .DEPTH(4)) dut (
    .C         (C),
    .INIT_N    (INIT_N),
    .I         (I),
    .EN        (EN),
    .EVT_READY (EVT_READY),
    .O         (O),
    .EVT_VALID (EVT_VALID),
    .EVT_KEY   (EVT_KEY),
    .EVT_TS    (EVT_TS),
    .OVERRUN   (OVERRUN),
    .BUSY      (BUSY)
  );

  always #5 C = ~C;

  typedef struct {
    int key;
    int ts;
  } exp_t;

  typedef struct {
    int   key;
    int   len;
    logic exp_o;
  } deb_vec_t;

  exp_t exp_q[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   run_edge = 0;

  always @(posedge C) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge C);
    #1;
  endtask

  task automatic start_run();
    EN = 1'b1;
    run_edge = cyc + 1;
    step(1);
  endtask

  // The event is stamped with TS in the first cycle O is high: 2+DEB edges after the drive.
  task automatic press(input int k);
    exp_t x;
    I[k] = 1'b1;
    x.key = k;
    x.ts  = (cyc + 2 + DEB - run_edge) % 256;
    exp_q.push_back(x);
  endtask

  task automatic wait_drain(input string name, input int max);
    for (int i = 0; i < max; i++) begin
      if (exp_q.size() == 0) break;
      step(1);
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    step(2);
    check({name, "_empty"}, 32'(EVT_VALID), 32'd0);
  endtask

  always @(negedge C) begin
    if (EVT_VALID === 1'b1 && EVT_READY === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_evt: got key %0d ts %0d, expected no event (cycle %0d)",
                 EVT_KEY, EVT_TS, cyc);
      end else begin
        e = exp_q.pop_front();
        check("evt_key", 32'(EVT_KEY), 32'(e.key));
        check("evt_ts", 32'(EVT_TS), 32'(e.ts));
      end
    end else if (EVT_VALID === 1'b0) begin
      check("head_zero_when_invalid", 32'({EVT_KEY, EVT_TS}), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000 ns");
    $fatal(1, "timeout");
  end

  initial begin
    deb_vec_t vecs[5];
    logic     seen;
    int       k;

    vecs[0] = '{key: 0, len: 1, exp_o: 1'b0};
    vecs[1] = '{key: 1, len: 3, exp_o: 1'b0};
    vecs[2] = '{key: 2, len: 4, exp_o: 1'b1};
    vecs[3] = '{key: 3, len: 6, exp_o: 1'b1};
    vecs[4] = '{key: 1, len: 5, exp_o: 1'b1};

    INIT_N = 1'b0;
    I = 4'd0;
    EN = 1'b0;
    EVT_READY = 1'b1;
    step(2);
    check("rst_o", 32'(O), 32'd0);
    check("rst_valid", 32'(EVT_VALID), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_overrun", 32'(OVERRUN), 32'd0);
    INIT_N = 1'b1;
    step(3);

    // Debounce table in IDLE: presses change O but never produce events
    for (int v = 0; v < 5; v++) begin
      k = vecs[v].key;
      seen = 1'b0;
      I[k] = 1'b1;
      for (int ed = 1; ed <= 8; ed++) begin
        step(1);
        seen = seen | O[k];
        if (ed == vecs[v].len) I[k] = 1'b0;
      end
      check($sformatf("deb_vec%0d_o", v), 32'(seen), 32'(vecs[v].exp_o));
      step(10);
      check($sformatf("deb_vec%0d_settled", v), 32'(O), 32'd0);
      check($sformatf("deb_vec%0d_no_evt", v), 32'(EVT_VALID), 32'd0);
      check($sformatf("deb_vec%0d_idle", v), 32'(BUSY), 32'd0);
    end

    // Single press: O[2] rises exactly 2+DEB cycles after I[2]
    start_run();
    check("run_busy", 32'(BUSY), 32'd1);
    step(3);
    press(2);
    step(1 + DEB);
    check("o2_before_rise", 32'(O[2]), 32'd0);
    step(1);
    check("o2_rise", 32'(O[2]), 32'd1);
    wait_drain("single", 20);
    I[2] = 1'b0;
    step(12);

    // Short glitch in RUN
    seen = 1'b0;
    I[1] = 1'b1;
    step(3);
    I[1] = 1'b0;
    for (int ed = 0; ed < 10; ed++) begin
      step(1);
      seen = seen | O[1];
    end
    check("glitch_o", 32'(seen), 32'd0);
    check("glitch_no_evt", 32'(EVT_VALID), 32'd0);
    check("glitch_overrun", 32'(OVERRUN), 32'd0);

    // Simultaneous rise: drained in key order with a shared stamp
    press(0);
    press(1);
    press(3);
    wait_drain("simul", 30);
    I = 4'd0;
    step(12);

    // Timestamp wrap past 255
    step(260);
    press(1);
    wait_drain("wrap", 30);
    I = 4'd0;
    step(12);

    // Full FIFO holds a pending event; a repeat press of it overruns
    EVT_READY = 1'b0;
    press(0);
    press(1);
    press(2);
    press(3);
    step(12);
    check("full_valid", 32'(EVT_VALID), 32'd1);
    check("full_head_key", 32'(EVT_KEY), 32'd0);
    I[0] = 1'b0;
    step(10);
    press(0);
    step(10);
    check("held_no_overrun", 32'(OVERRUN), 32'd0);
    check("held_head_key", 32'(EVT_KEY), 32'd0);
    I[0] = 1'b0;
    step(10);
    I[0] = 1'b1;
    step(10);
    check("repeat_overrun", 32'(OVERRUN), 32'd1);
    EVT_READY = 1'b1;
    wait_drain("full", 30);
    check("overrun_sticky", 32'(OVERRUN), 32'd1);
    I = 4'd0;
    step(12);

    // Flush: BUSY holds until the last pop, then IDLE
    EVT_READY = 1'b0;
    press(2);
    step(10);
    check("flush_queued", 32'(EVT_VALID), 32'd1);
    EN = 1'b0;
    step(5);
    check("flush_busy", 32'(BUSY), 32'd1);
    EVT_READY = 1'b1;
    begin : wait_pop
      for (int i = 0; i < 20; i++) begin
        step(1);
        if (EVT_VALID == 1'b0) disable wait_pop;
      end
    end
    check("flush_popped", 32'(EVT_VALID), 32'd0);
    check("busy_after_last_pop", 32'(BUSY), 32'd1);
    step(1);
    check("idle_after_flush", 32'(BUSY), 32'd0);
    check("flush_sb_empty", 32'(exp_q.size()), 32'd0);
    I[2] = 1'b0;
    step(12);
    I[3] = 1'b1;
    step(12);
    check("idle_press_o", 32'(O[3]), 32'd1);
    check("idle_press_no_evt", 32'(EVT_VALID), 32'd0);
    I = 4'd0;
    step(12);

    // Reset mid-operation with three queued events
    start_run();
    EVT_READY = 1'b0;
    press(0);
    press(1);
    press(2);
    step(12);
    check("pre_rst_valid", 32'(EVT_VALID), 32'd1);
    #2;
    INIT_N = 1'b0;
    #1;
    check("async_rst_valid", 32'(EVT_VALID), 32'd0);
    check("async_rst_outs", 32'({O, EVT_KEY, EVT_TS, OVERRUN, BUSY}), 32'd0);
    exp_q.delete();
    I = 4'd0;
    EN = 1'b0;
    step(2);
    check("rst_held_valid", 32'(EVT_VALID), 32'd0);
    INIT_N = 1'b1;
    step(3);
    check("post_rst_idle", 32'(BUSY), 32'd0);
    EVT_READY = 1'b1;
    start_run();
    step(2);
    press(3);
    wait_drain("post_rst", 30);
    I = 4'd0;
    step(12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_event_ctrl.md
KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

Interface
REQ-001 Parameter DEBOUNCE, default 4: cycles a synchronised key level must hold before O changes.
REQ-002 Parameter DEPTH, default 4: event FIFO entries, power of two.
REQ-003 C  in  1  single system clock; all state updates on its rising edge.
REQ-004 INIT_N  in  1  reset, asynchronous, active-low.
REQ-005 I  in  4  raw key levels, asynchronous to C, 1 = pressed.
REQ-006 EN  in  1  game-running enable, synchronous to C.
REQ-007 EVT_READY  in  1  consumer accepts the head event.
REQ-008 O  out  4  debounced key levels.
REQ-009 EVT_VALID  out  1  FIFO non-empty; head event presented.
REQ-010 EVT_KEY  out  2  key index of head event.
REQ-011 EVT_TS  out  8  timestamp of head event.
REQ-012 OVERRUN  out  1  sticky flag: a press event was lost.
REQ-013 BUSY  out  1  high when the FSM is not in IDLE.

Function
REQ-014 Each I bit SHALL pass a 2-flop synchroniser; a level stable at the synchroniser output for DEBOUNCE consecutive cycles SHALL update O, giving a total I-to-O latency of 2+DEBOUNCE cycles.
REQ-015 A synchronised level that reverts before DEBOUNCE cycles SHALL clear that key's counter and leave O unchanged.
REQ-016 The FSM SHALL have three states: IDLE (capture off), RUN (capture on), FLUSH (capture off, FIFO draining).
REQ-017 Transitions: IDLE->RUN when EN=1; RUN->FLUSH when EN=0; FLUSH->IDLE when the FIFO is empty and no pending bit is set; FLUSH->RUN when EN=1.
REQ-018 The 8-bit TS counter SHALL clear to 0 on the IDLE->RUN transition, increment once per cycle in RUN, wrap 255->0, and hold its value in FLUSH and IDLE.
REQ-019 In RUN, a 0->1 transition of O[k] SHALL set pending[k] and latch the current TS value into stamp[k].
REQ-020 A 0->1 transition of O[k] while pending[k] is already set SHALL drop the new event, keep the old stamp, and set OVERRUN.
REQ-021 Arbiter: each cycle, if any pending bit is set and the FIFO is not full, push {lowest set index, its stamp} and clear that pending bit; at most one push per cycle.
REQ-022 Pending bits SHALL be serviced in RUN and FLUSH and SHALL be held while the FIFO is full.
REQ-023 Pop SHALL occur when EVT_VALID=1 and EVT_READY=1; EVT_KEY and EVT_TS SHALL show the next entry on the following cycle.
REQ-024 A push and pop in the same cycle SHALL both occur, including when the FIFO is full; occupancy is then unchanged.
REQ-025 A push into an empty FIFO SHALL raise EVT_VALID on the following cycle; there is no bypass path.
REQ-026 EVT_KEY and EVT_TS SHALL be 0 when EVT_VALID=0.
REQ-027 OVERRUN SHALL clear only on reset.
REQ-028 Release edges (1->0) SHALL generate no events.

Reset
REQ-029 INIT_N=0 SHALL immediately force: FSM IDLE, O=0, synchronisers=0, debounce counters=0, pending=0, stamps=0, TS=0, FIFO empty, EVT_VALID=0, EVT_KEY=0, EVT_TS=0, OVERRUN=0, BUSY=0.
REQ-030 Reset asserted mid-operation SHALL discard all queued and pending events; after release the block SHALL behave as if newly powered up.
REQ-031 Reset release SHALL be synchronised to C before it reaches state flops.

Structure
REQ-032 The shared package SHALL hold the key count (4), TS width (8), FSM state encoding, and the defaults for DEBOUNCE and DEPTH.
REQ-033 Per-key synchronising and debouncing SHALL be a sub-module named key_debounce, instantiated four times; the FIFO, arbiter and FSM SHALL reside in key_event_ctrl.

Verification
REQ-034 EN=1, I[2] 0->1 held -> O[2] rises 6 cycles later; one event is pushed with EVT_KEY=2 and EVT_TS equal to the TS value at the O rise.
REQ-035 I[1] pulses high for 3 cycles -> O stays 0, no event, OVERRUN=0.
REQ-036 Keys 0, 1 and 3 rise together with EVT_READY=1 -> events are pushed on consecutive cycles in key order 0, 1, 3, all carrying the same TS.
REQ-037 EVT_READY=0, DEPTH=4, five distinct presses -> four events are queued, the fifth is held pending; a repeat press of the held key sets OVERRUN; once EVT_READY=1, all five events drain in order.
REQ-038 Event queued, EN dropped -> BUSY stays 1 through FLUSH until the last pop, then the FSM returns to IDLE and BUSY=0; a press made in IDLE produces no event.
REQ-039 INIT_N pulsed low with 3 events queued -> EVT_VALID=0 and all outputs are 0 asynchronously; TS restarts at 0 on the next RUN entry.
